// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO ownership: computes the full result on acceptance,
// then holds it in a pending register until the configured latency has elapsed.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] pend_hi, pend_lo, pend_hi_nx, pend_lo_nx, hi_nx, lo_nx;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   abs_a, abs_b, q_mag, r_mag, quot_s, rem_s, quot_u, rem_u;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               a_neg, b_neg, div_zero, div_ovf;

  // Signed multiply via sign-extended operands: the low 2*WIDTH bits of the
  // unsigned product equal the two's-complement signed product.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign a_neg    = a[WIDTH-1];
  assign b_neg    = b[WIDTH-1];
  assign abs_a    = a_neg ? -a : a;
  assign abs_b    = b_neg ? -b : b;
  assign q_mag    = abs_a / abs_b;
  assign r_mag    = abs_a % abs_b;
  assign quot_s   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem_s    = a_neg ? -r_mag : r_mag;
  assign quot_u   = a / b;
  assign rem_u    = a % b;
  assign div_zero = (b == '0);
  assign div_ovf  = (a == MOST_NEG) && (b == '1);

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (op)
      3'd0: {res_hi, res_lo} = prod_s;
      3'd1: {res_hi, res_lo} = prod_u;
      3'd2: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = '1;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = a;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      3'd3: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = '1;
        end else begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    hi_nx      = hi;
    lo_nx      = lo;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1: begin
              pend_hi_nx = res_hi;
              pend_lo_nx = res_lo;
              cnt_nx     = CNT_W'(MULT_CYCLES);
              state_nx   = RUN;
            end
            3'd2, 3'd3: begin
              pend_hi_nx = res_hi;
              pend_lo_nx = res_lo;
              cnt_nx     = CNT_W'(DIV_CYCLES);
              state_nx   = RUN;
            end
            3'd4:    hi_nx = a;
            3'd5:    lo_nx = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          hi_nx    = pend_hi;
          lo_nx    = pend_lo;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
      hi      <= hi_nx;
      lo      <= lo_nx;
    end
  end

  assign busy = (state == RUN);

endmodule
